match_status_monitor: RTL and testbench
=======================================

// Module: match_status_monitor
// PURPOSE
//  Parametrised multi-channel pattern detector with sticky status. Each channel compares
//  its data word against a shared masked pattern, requires HOLD consecutive valid matches
//  (debounce), then sets a sticky status bit, bumps a saturating hit counter and raises
//  a maskable interrupt. Sits beside datapath blocks as a generic event/status monitor.
// PARAMETERS
//  N_CH  2   number of independent channels (>=1)
//  W     4   data/pattern/mask width per channel (>=1)
//  HOLD  1   consecutive valid matching samples needed to qualify a hit (1..255)
//  CW    8   hit counter width per channel (>=1)
// PORTS
//  clk      in   1        clock, all state updates on rising edge
//  rstn     in   1        asynchronous reset, ACTIVE-HIGH (1 = reset)
//  in_valid in   1        qualifies in_data this cycle; common to all channels
//  in_data  in   N_CH*W   channel c data at [c*W +: W]
//  pattern  in   W        compare value, shared by all channels
//  mask     in   W        1 = bit compared, 0 = don't care
//  clr      in   N_CH     per-channel clear of status and hit counter
//  irq_en   in   N_CH     per-channel interrupt enable
//  status   out  N_CH     sticky per-channel hit flag
//  hit_cnt  out  N_CH*CW  channel c counter at [c*CW +: CW]
//  irq      out  1        |(status & irq_en), combinational from registers
// BEHAVIOUR
//  - Reset (rstn=1, async): status=0, hit_cnt=0, all FSMs IDLE, run counters 0; irq=0.
//  - match[c] = in_valid & (((in_data[c] ^ pattern) & mask) == 0). mask=0 -> any valid matches.
//  - in_valid=0 cycles are invisible: FSM state and run count hold.
//  - Per-channel FSM, states IDLE / QUAL / HIT:
//    IDLE: match & HOLD==1 -> HIT (hit event); match & HOLD>1 -> QUAL, run=1; else stay.
//    QUAL: match -> run+1; when run+1==HOLD -> HIT (hit event). valid & !match -> IDLE, run=0.
//    HIT : valid & !match -> IDLE (re-arm); otherwise stay. No further events while in HIT.
//  - Hit event: status[c]<=1; hit_cnt[c]<=hit_cnt[c]+1, saturating at 2^CW-1 (no wrap).
//  - One hit per qualified episode: a continuous match run counts once, however long.
//  - Latency: status/hit_cnt update on the edge that samples the HOLD-th consecutive
//    valid match; irq follows combinationally in the same cycle.
//  - clr[c]: status[c]<=0, hit_cnt[c]<=0 on that edge; FSM unaffected (stays in HIT
//    if there, so a held match does NOT re-fire after clear).
//  - clr[c] and hit event same edge: event wins -> status[c]=1, hit_cnt[c]=1.
//  - irq_en change affects irq immediately; status is not altered by irq_en.
//  - Reset mid-QUAL/HIT: all progress discarded; qualification restarts from IDLE.
//  - pattern/mask changes take effect on next sample; in-progress run count kept.
//  - Channels fully independent except shared in_valid/pattern/mask.
// TESTING (N_CH=2, W=4, CW=4, pattern=4'b0001, mask=4'b1110 unless stated)
//  1 HOLD=1: ch0 data 4'h0 valid 1 cycle -> status=2'b01, hit_cnt ch0=1 next cycle; irq=1
//    with irq_en=2'b01, irq=0 with irq_en=2'b10.
//  2 HOLD=3: ch1 valid matches 2 cycles, 1 mismatch, then 3 matches -> no hit after the
//    first 2; status[1]=1, cnt=1 exactly at 3rd match of second run; valid=0 gaps inside
//    the run do not break qualification.
//  3 HOLD=1: ch0 matches 20 cycles continuously -> hit_cnt=1; then 16 episodes
//    (match,mismatch pairs) -> hit_cnt saturates at 4'hF, stays 4'hF.
//  4 clr=2'b01 while ch0 in HIT with match held -> status[0]=0, cnt=0, no re-fire;
//    clr coincident with hit event -> status[0]=1, cnt=1.
//  5 rstn pulsed 1 mid-QUAL (HOLD=3, after 2 matches) -> all outputs 0; next 2 matches
//    give no hit, 3rd gives hit.
//  6 mask=4'b0000 with in_valid=1 and random data -> both channels hit; in_valid=0 -> none.

Source files
------------

// File: rtl/match_status_monitor.sv
// Multi-channel masked pattern detector: per-channel debounce FSM, sticky status,
// saturating hit counter and a maskable OR-reduced interrupt.
module match_status_monitor #(
    parameter int N_CH = 2,
    parameter int W    = 4,
    parameter int HOLD = 1,
    parameter int CW   = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [W-1:0]      pattern,
    input  logic [W-1:0]      mask,
    input  logic [N_CH-1:0]   clr,
    input  logic [N_CH-1:0]   irq_en,
    output logic [N_CH-1:0]   status,
    output logic [N_CH*CW-1:0] hit_cnt,
    output logic              irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_QUAL = 2'd1;
    localparam logic [1:0] S_HIT  = 2'd2;

    localparam logic [7:0] HOLD_L = 8'(HOLD);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [W-1:0]  data;
        logic          match;
        logic          hit_ev;
        logic [1:0]    state;
        logic [1:0]    state_nxt;
        logic [7:0]    run;
        logic [7:0]    run_nxt;
        logic          sticky;
        logic [CW-1:0] cnt;

        assign data  = in_data[c*W +: W];
        assign match = in_valid && (((data ^ pattern) & mask) == '0);

        // Invalid cycles leave state and run untouched, so gaps never break a run.
        always_comb begin
            state_nxt = state;
            run_nxt   = run;
            hit_ev    = 1'b0;
            case (state)
                S_IDLE: begin
                    if (match) begin
                        if (HOLD_L == 8'd1) begin
                            state_nxt = S_HIT;
                            hit_ev    = 1'b1;
                        end else begin
                            state_nxt = S_QUAL;
                            run_nxt   = 8'd1;
                        end
                    end
                end
                S_QUAL: begin
                    if (match) begin
                        if (run + 8'd1 == HOLD_L) begin
                            state_nxt = S_HIT;
                            run_nxt   = '0;
                            hit_ev    = 1'b1;
                        end else begin
                            run_nxt = run + 8'd1;
                        end
                    end else if (in_valid) begin
                        state_nxt = S_IDLE;
                        run_nxt   = '0;
                    end
                end
                S_HIT: begin
                    if (in_valid && !match) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    run_nxt   = '0;
                end
            endcase
        end

        // A hit coinciding with clr counts into a freshly cleared counter.
        always_ff @(posedge clk or posedge rstn) begin
            if (rstn) begin
                state  <= S_IDLE;
                run    <= '0;
                sticky <= 1'b0;
                cnt    <= '0;
            end else begin
                state <= state_nxt;
                run   <= run_nxt;
                if (hit_ev) begin
                    sticky <= 1'b1;
                    if (clr[c]) begin
                        cnt <= CW'(1);
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end else if (clr[c]) begin
                    sticky <= 1'b0;
                    cnt    <= '0;
                end
            end
        end

        assign status[c]             = sticky;
        assign hit_cnt[c*CW +: CW]   = cnt;
    end

    assign irq = |(status & irq_en);

endmodule

// File: tb/tb_match_status_monitor.sv
// Scoreboarded bench for match_status_monitor: HOLD=1 and HOLD=3 instances share stimulus.
module tb_match_status_monitor;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       in_valid;
    logic [7:0] in_data;
    logic [3:0] pattern;
    logic [3:0] mask;
    logic [1:0] clr;
    logic [1:0] irq_en;
    logic [1:0] st1, st3;
    logic [7:0] cnt1, cnt3;
    logic       irq1, irq3;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    match_status_monitor #(.N_CH(2), .W(4), .HOLD(1), .CW(4)) dut_h1 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
        .pattern(pattern), .mask(mask), .clr(clr), .irq_en(irq_en),
        .status(st1), .hit_cnt(cnt1), .irq(irq1)
    );

    match_status_monitor #(.N_CH(2), .W(4), .HOLD(3), .CW(4)) dut_h3 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
        .pattern(pattern), .mask(mask), .clr(clr), .irq_en(irq_en),
        .status(st3), .hit_cnt(cnt3), .irq(irq3)
    );

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [15:0] cnt;
        logic [1:0]  irq;
    } exp_t;

    exp_t sb[$];

    // Reference model: index [inst][ch], inst 0 = HOLD 1, inst 1 = HOLD 3
    int         streak[2][2];
    bit         fired[2][2];
    bit         m_st[2][2];
    logic [3:0] m_cnt[2][2];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                streak[i][c] = 0;
                fired[i][c]  = 1'b0;
                m_st[i][c]   = 1'b0;
                m_cnt[i][c]  = 4'd0;
            end
        end
    endtask

    task automatic reset_dut(input string tag);
        rstn = 1'b1;
        model_reset();
        #2;
        check({tag, ".rst_st"},  16'({st3, st1}),   16'd0);
        check({tag, ".rst_cnt"}, 16'({cnt3, cnt1}), 16'd0);
        check({tag, ".rst_irq"}, 16'({irq3, irq1}), 16'd0);
        rstn = 1'b0;
        #1;
    endtask

    task automatic step(input string tag);
        exp_t       e;
        int         h;
        logic [3:0] d;
        bit         mt, fire;
        for (int i = 0; i < 2; i++) begin
            h = (i == 0) ? 1 : 3;
            for (int c = 0; c < 2; c++) begin
                d    = in_data[c*4 +: 4];
                mt   = in_valid && (((d ^ pattern) & mask) == 4'd0);
                fire = 1'b0;
                if (in_valid) begin
                    if (mt) begin
                        streak[i][c]++;
                        if (!fired[i][c] && streak[i][c] >= h) begin
                            fire        = 1'b1;
                            fired[i][c] = 1'b1;
                        end
                    end else begin
                        streak[i][c] = 0;
                        fired[i][c]  = 1'b0;
                    end
                end
                if (fire) begin
                    m_st[i][c]  = 1'b1;
                    m_cnt[i][c] = clr[c] ? 4'd1 : ((m_cnt[i][c] == 4'hF) ? 4'hF : m_cnt[i][c] + 4'd1);
                end else if (clr[c]) begin
                    m_st[i][c]  = 1'b0;
                    m_cnt[i][c] = 4'd0;
                end
            end
        end
        e.tag = tag;
        e.st  = {m_st[1][1], m_st[1][0], m_st[0][1], m_st[0][0]};
        e.cnt = {m_cnt[1][1], m_cnt[1][0], m_cnt[0][1], m_cnt[0][0]};
        e.irq = {|(e.st[3:2] & irq_en), |(e.st[1:0] & irq_en)};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.tag, ".st"},  16'({st3, st1}),   16'(e.st));
        check({e.tag, ".cnt"}, {cnt3, cnt1},      e.cnt);
        check({e.tag, ".irq"}, 16'({irq3, irq1}), 16'(e.irq));
    endtask

    initial begin
        in_valid = 1'b0;
        in_data  = 8'h00;
        pattern  = 4'b0001;
        mask     = 4'b1110;
        clr      = 2'b00;
        irq_en   = 2'b01;
        reset_dut("init");

        // 1: single-cycle hit on ch0 (ch1 data F never matches)
        in_valid = 1'b1; in_data = 8'hF0;
        step("t1.hit");
        check("t1.status", 16'(st1), 16'(2'b01));
        check("t1.cnt0",   16'(cnt1[3:0]), 16'd1);
        check("t1.irq_en01", 16'(irq1), 16'd1);
        irq_en = 2'b10;
        #1;
        check("t1.irq_en10", 16'(irq1), 16'd0);
        in_valid = 1'b0;
        step("t1.idle");

        // 2: HOLD=3 on ch1 with an interrupted run and valid gaps
        reset_dut("t2");
        irq_en = 2'b11;
        in_valid = 1'b1; in_data = 8'h0F;
        step("t2.m1");
        step("t2.m2");
        check("t2.no_hit_2", 16'(cnt3[7:4]), 16'd0);
        in_data = 8'hFF;
        step("t2.miss");
        in_data = 8'h0F;
        step("t2.r1");
        in_valid = 1'b0; step("t2.gap1");
        in_valid = 1'b1; step("t2.r2");
        in_valid = 1'b0; step("t2.gap2");
        check("t2.no_hit_r2", 16'(st3[1]), 16'd0);
        in_valid = 1'b1; step("t2.r3");
        check("t2.hit_st", 16'(st3[1]), 16'd1);
        check("t2.hit_cnt", 16'(cnt3[7:4]), 16'd1);

        // 3: long run counts once, then episodes saturate the counter
        reset_dut("t3");
        in_data = 8'hF0;
        for (int i = 0; i < 20; i++) step("t3.run");
        check("t3.once", 16'(cnt1[3:0]), 16'd1);
        for (int i = 0; i < 18; i++) begin
            in_data = 8'hF0; step("t3.ep_m");
            in_data = 8'hFF; step("t3.ep_x");
        end
        check("t3.sat", 16'(cnt1[3:0]), 16'hF);

        // 4: clear while held in HIT, then clear coincident with a hit
        reset_dut("t4");
        in_data = 8'hF0;
        step("t4.hit");
        step("t4.hold");
        clr = 2'b01; step("t4.clr");
        check("t4.clr_st", 16'(st1[0]), 16'd0);
        check("t4.clr_cnt", 16'(cnt1[3:0]), 16'd0);
        clr = 2'b00;
        step("t4.held1");
        step("t4.held2");
        check("t4.no_refire", 16'(cnt1[3:0]), 16'd0);
        in_data = 8'hFF; step("t4.rearm");
        in_data = 8'hF0; clr = 2'b01; step("t4.clr_hit");
        check("t4.win_st", 16'(st1[0]), 16'd1);
        check("t4.win_cnt", 16'(cnt1[3:0]), 16'd1);
        clr = 2'b00;

        // 5: reset in the middle of qualification
        reset_dut("t5a");
        in_data = 8'hF0;
        step("t5.q1");
        step("t5.q2");
        reset_dut("t5b");
        step("t5.a1");
        step("t5.a2");
        check("t5.no_hit", 16'(cnt3[3:0]), 16'd0);
        step("t5.a3");
        check("t5.hit", 16'(cnt3[3:0]), 16'd1);

        // 6: mask 0 makes any valid sample a match
        reset_dut("t6a");
        mask = 4'b0000;
        in_data = 8'($urandom);
        step("t6.any1");
        check("t6.both_h1", 16'(st1), 16'(2'b11));
        in_data = 8'($urandom); step("t6.any2");
        in_data = 8'($urandom); step("t6.any3");
        check("t6.both_h3", 16'(st3), 16'(2'b11));
        reset_dut("t6b");
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'($urandom);
            step("t6.inval");
        end
        check("t6.none", 16'({st3, st1}), 16'd0);

        // Random mix against the model
        reset_dut("rnd");
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) pattern = 4'($urandom);
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
            in_data = {($urandom_range(0, 2) == 0) ? 4'($urandom) : pattern,
                       ($urandom_range(0, 2) == 0) ? 4'($urandom) : pattern};
            clr    = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            irq_en = 2'($urandom);
            if ($urandom_range(0, 79) == 0) reset_dut("rnd.rst");
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
